seq_stage_sequencer: RTL and testbench

//  Multi-cycle control FSM for the sequential RV64 core. It steps one instruction at a time through

---
 rtl/seq_pkg.sv | 27 ++
 rtl/seq_stage_sequencer_if.sv | 41 ++++
 rtl/seq_wait_timer.sv | 33 +++
 rtl/seq_stage_sequencer.sv | 178 +++++++++++++++++
 tb/tb_seq_stage_sequencer.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/seq_pkg.sv
// Shared types and constants for the multi-cycle RV64 stage sequencer.
package seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FETCH   = 3'd1,
    ST_DECODE  = 3'd2,
    ST_EXECUTE = 3'd3,
    ST_MEM     = 3'd4,
    ST_WB      = 3'd5,
    ST_HALT    = 3'd6
  } state_e;

  localparam logic [6:0]  OP_RTYPE  = 7'b0110011;
  localparam logic [6:0]  OP_ITYPE  = 7'b0010011;
  localparam logic [6:0]  OP_LOAD   = 7'b0000011;
  localparam logic [6:0]  OP_STORE  = 7'b0100011;
  localparam logic [6:0]  OP_BRANCH = 7'b1100011;

  localparam logic [31:0] HALT_SENTINEL = 32'h0000_0000;

  function automatic logic opcode_legal(input logic [6:0] op);
    return (op == OP_RTYPE) || (op == OP_ITYPE) || (op == OP_LOAD) ||
           (op == OP_STORE) || (op == OP_BRANCH);
  endfunction

endpackage

// File: rtl/seq_stage_sequencer_if.sv
// Control bundle between the stage sequencer (master) and the datapath/memories (slave).
interface seq_stage_sequencer_if;

  logic        start;
  logic        imem_ready;
  logic        dmem_ready;
  logic [31:0] instr;
  logic [6:0]  opcode;
  logic        branch;
  logic        memread;
  logic        memwrite;
  logic        regwrite;
  logic        branch_taken;

  logic        imem_req;
  logic        ir_load;
  logic        dmem_req;
  logic        dmem_we;
  logic        rf_we;
  logic        pc_en;
  logic        pc_sel;
  logic        busy;
  logic        halted;
  logic        err_illegal;
  logic        err_timeout;

  modport master (
    input  start, imem_ready, dmem_ready, instr, opcode,
           branch, memread, memwrite, regwrite, branch_taken,
    output imem_req, ir_load, dmem_req, dmem_we, rf_we, pc_en, pc_sel,
           busy, halted, err_illegal, err_timeout
  );

  modport slave (
    output start, imem_ready, dmem_ready, instr, opcode,
           branch, memread, memwrite, regwrite, branch_taken,
    input  imem_req, ir_load, dmem_req, dmem_we, rf_we, pc_en, pc_sel,
           busy, halted, err_illegal, err_timeout
  );

endinterface

// File: rtl/seq_wait_timer.sv
// Handshake wait counter: counts stalled cycles, 'expired' marks the last allowed one.
module seq_wait_timer #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);

  if (MEM_TIMEOUT == 0) begin : g_forever
    assign o_expired = 1'b0;
  end else begin : g_limit
    localparam int CW = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_cnt <= '0;
      end else if (i_clr) begin
        r_cnt <= '0;
      end else if (i_en) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end

    // Asserted during the MEM_TIMEOUT-th stalled cycle; a ready in that cycle still wins.
    assign o_expired = (r_cnt == CW'(MEM_TIMEOUT - 1));
  end

endmodule

// File: rtl/seq_stage_sequencer.sv
// Multi-cycle FETCH/DECODE/EXECUTE/MEM/WB control FSM for the sequential RV64 core.
// Optional build macro SEQ_PERF_CNT_EN adds cycle_cnt / retired_cnt performance counters.
module seq_stage_sequencer
  import seq_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  seq_stage_sequencer_if.master bus
`ifdef SEQ_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]      cycle_cnt,
  output logic [CNT_W-1:0]      retired_cnt
`endif
);

  if (MEM_TIMEOUT < 0 || CNT_W < 1) begin : g_param_check
    $error("seq_stage_sequencer: MEM_TIMEOUT must be >= 0 and CNT_W >= 1");
  end

  state_e r_state, w_next;
  logic   r_branch, r_memread, r_memwrite, r_regwrite;
  logic   r_err_illegal, r_err_timeout;
  logic   w_imem_req, w_ir_load, w_dmem_req, w_dmem_we, w_rf_we, w_pc_en, w_pc_sel;
  logic   w_set_illegal, w_set_timeout, w_wait, w_expired, w_restart, w_busy;

  assign w_restart = (r_state == ST_HALT) && bus.start;
  assign w_busy    = (r_state != ST_IDLE) && (r_state != ST_HALT);

  seq_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_clr    (!((r_state == ST_FETCH) || (r_state == ST_MEM))),
    .i_en     (w_wait),
    .o_expired(w_expired)
  );

  always_comb begin
    w_next        = r_state;
    w_imem_req    = 1'b0;
    w_ir_load     = 1'b0;
    w_dmem_req    = 1'b0;
    w_dmem_we     = 1'b0;
    w_rf_we       = 1'b0;
    w_pc_en       = 1'b0;
    w_pc_sel      = 1'b0;
    w_set_illegal = 1'b0;
    w_set_timeout = 1'b0;
    w_wait        = 1'b0;
    unique case (r_state)
      ST_IDLE: if (bus.start) w_next = ST_FETCH;
      ST_FETCH: begin
        w_imem_req = 1'b1;
        if (bus.imem_ready) begin
          w_ir_load = 1'b1;
          w_next    = ST_DECODE;
        end else begin
          w_wait = 1'b1;
          if (w_expired) begin
            w_set_timeout = 1'b1;
            w_next        = ST_HALT;
          end
        end
      end
      ST_DECODE: begin
        if (bus.instr == HALT_SENTINEL) begin
          w_next = ST_HALT;
        end else if (!opcode_legal(bus.opcode)) begin
          w_set_illegal = 1'b1;
          w_next        = ST_HALT;
        end else begin
          w_next = ST_EXECUTE;
        end
      end
      // Register-only ops write back here so they retire in three cycles; WB serves loads.
      ST_EXECUTE: begin
        if (r_memread || r_memwrite) begin
          w_next = ST_MEM;
        end else if (r_regwrite) begin
          w_rf_we = 1'b1;
          w_pc_en = 1'b1;
          w_next  = ST_FETCH;
        end else begin
          w_pc_en  = 1'b1;
          w_pc_sel = r_branch && bus.branch_taken;
          w_next   = ST_FETCH;
        end
      end
      ST_MEM: begin
        w_dmem_req = 1'b1;
        w_dmem_we  = r_memwrite;
        if (bus.dmem_ready) begin
          if (r_memread) begin
            w_next = ST_WB;
          end else begin
            w_pc_en = 1'b1;
            w_next  = ST_FETCH;
          end
        end else begin
          w_wait = 1'b1;
          if (w_expired) begin
            w_set_timeout = 1'b1;
            w_next        = ST_HALT;
          end
        end
      end
      ST_WB: begin
        w_rf_we = 1'b1;
        w_pc_en = 1'b1;
        w_next  = ST_FETCH;
      end
      ST_HALT: if (bus.start) w_next = ST_FETCH;
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_branch      <= 1'b0;
      r_memread     <= 1'b0;
      r_memwrite    <= 1'b0;
      r_regwrite    <= 1'b0;
      r_err_illegal <= 1'b0;
      r_err_timeout <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == ST_DECODE) begin
        r_branch   <= bus.branch;
        r_memread  <= bus.memread;
        r_memwrite <= bus.memwrite;
        r_regwrite <= bus.regwrite;
      end
      if (w_restart) begin
        r_err_illegal <= 1'b0;
        r_err_timeout <= 1'b0;
      end else begin
        if (w_set_illegal) r_err_illegal <= 1'b1;
        if (w_set_timeout) r_err_timeout <= 1'b1;
      end
    end
  end

`ifdef SEQ_PERF_CNT_EN
  logic [CNT_W-1:0] r_cycle_cnt, r_retired_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cycle_cnt   <= '0;
      r_retired_cnt <= '0;
    end else if (w_restart) begin
      r_cycle_cnt   <= '0;
      r_retired_cnt <= '0;
    end else begin
      if (w_busy)  r_cycle_cnt   <= r_cycle_cnt + 1'b1;
      if (w_pc_en) r_retired_cnt <= r_retired_cnt + 1'b1;
    end
  end

  assign cycle_cnt   = r_cycle_cnt;
  assign retired_cnt = r_retired_cnt;
`endif

  assign bus.imem_req    = w_imem_req;
  assign bus.ir_load     = w_ir_load;
  assign bus.dmem_req    = w_dmem_req;
  assign bus.dmem_we     = w_dmem_we;
  assign bus.rf_we       = w_rf_we;
  assign bus.pc_en       = w_pc_en;
  assign bus.pc_sel      = w_pc_sel;
  assign bus.busy        = w_busy;
  assign bus.halted      = (r_state == ST_HALT);
  assign bus.err_illegal = r_err_illegal;
  assign bus.err_timeout = r_err_timeout;

endmodule

// File: tb/tb_seq_stage_sequencer.sv
// Table-driven bench for seq_stage_sequencer; perf-counter checks are built with SEQ_PERF_CNT_EN.
module tb_seq_stage_sequencer;

  localparam int TO = 4;

  localparam logic [31:0] I_ADD = 32'h003100B3;
  localparam logic [31:0] I_LD  = 32'h00013083;
  localparam logic [31:0] I_BEQ = 32'h00208463;
  localparam logic [31:0] I_SD  = 32'h00113023;
  localparam logic [31:0] I_LUI = 32'h000000B7;
  localparam logic [31:0] I_END = 32'h00000000;

  // decoder flags {branch, memread, memwrite, regwrite, branch_taken}
  localparam logic [4:0] F_ALU = 5'b00010;
  localparam logic [4:0] F_LD  = 5'b01010;
  localparam logic [4:0] F_SD  = 5'b00100;
  localparam logic [4:0] F_BRT = 5'b10001;
  localparam logic [4:0] F_BRN = 5'b10000;
  localparam logic [4:0] F_0   = 5'b00000;

  // {imem_req, ir_load, dmem_req, dmem_we, rf_we, pc_en, pc_sel, busy, halted, err_illegal, err_timeout}
  localparam logic [10:0] E_IDLE = 11'b00000000000;
  localparam logic [10:0] E_FQ   = 11'b10000001000;
  localparam logic [10:0] E_FR   = 11'b11000001000;
  localparam logic [10:0] E_BUSY = 11'b00000001000;
  localparam logic [10:0] E_RET  = 11'b00001101000;
  localparam logic [10:0] E_MEMR = 11'b00100001000;
  localparam logic [10:0] E_MEMW = 11'b00110001000;
  localparam logic [10:0] E_STR  = 11'b00110101000;
  localparam logic [10:0] E_BRT  = 11'b00000111000;
  localparam logic [10:0] E_BRN  = 11'b00000101000;
  localparam logic [10:0] E_HALT = 11'b00000000100;
  localparam logic [10:0] E_HILL = 11'b00000000110;
  localparam logic [10:0] E_HTO  = 11'b00000000101;

  typedef struct {
    string       name;
    logic        start;
    logic        ir;
    logic        dr;
    logic [31:0] instr;
    logic [4:0]  fl;
    logic [10:0] exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;
  vec_t tv[$];

  always #5 clk = ~clk;

  seq_stage_sequencer_if bus();

`ifdef SEQ_PERF_CNT_EN
  logic [31:0] cycle_cnt, retired_cnt;
`endif

  seq_stage_sequencer #(.MEM_TIMEOUT(TO), .CNT_W(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus)
`ifdef SEQ_PERF_CNT_EN
    ,
    .cycle_cnt  (cycle_cnt),
    .retired_cnt(retired_cnt)
`endif
  );

  function automatic logic [10:0] outs();
    return {bus.imem_req, bus.ir_load, bus.dmem_req, bus.dmem_we, bus.rf_we, bus.pc_en,
            bus.pc_sel, bus.busy, bus.halted, bus.err_illegal, bus.err_timeout};
  endfunction

  task automatic drive(input logic s, input logic ir, input logic dr,
                       input logic [31:0] ins, input logic [4:0] fl);
    bus.start      = s;
    bus.imem_ready = ir;
    bus.dmem_ready = dr;
    bus.instr      = ins;
    bus.opcode     = ins[6:0];
    {bus.branch, bus.memread, bus.memwrite, bus.regwrite, bus.branch_taken} = fl;
  endtask

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%b exp=%b", nm, got, exp);
    end
  endtask

  // One FSM cycle: drive after the falling edge, sample before the next rising edge.
  task automatic cyc(input string nm, input logic s, input logic ir, input logic dr,
                     input logic [31:0] ins, input logic [4:0] fl, input logic [10:0] e);
    @(negedge clk);
    drive(s, ir, dr, ins, fl);
    #2;
    check(nm, {21'd0, outs()}, {21'd0, e});
  endtask

  task automatic add(input string n, input logic s, input logic ir, input logic dr,
                     input logic [31:0] ins, input logic [4:0] fl, input logic [10:0] e);
    vec_t v;
    v.name = n; v.start = s; v.ir = ir; v.dr = dr; v.instr = ins; v.fl = fl; v.exp = e;
    tv.push_back(v);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    add("idle",        0, 0, 0, I_END, F_0,   E_IDLE);
    add("idle_start",  1, 0, 0, I_END, F_0,   E_IDLE);
    add("add_fetch",   0, 1, 0, I_ADD, F_ALU, E_FR);
    add("add_decode",  1, 0, 0, I_ADD, F_ALU, E_BUSY);
    add("add_exec",    0, 0, 0, I_ADD, F_ALU, E_RET);
    add("ld_fetch",    0, 1, 0, I_LD,  F_LD,  E_FR);
    add("ld_decode",   0, 0, 0, I_LD,  F_LD,  E_BUSY);
    add("ld_exec",     0, 0, 0, I_LD,  F_LD,  E_BUSY);
    add("ld_mem_w0",   0, 0, 0, I_LD,  F_LD,  E_MEMR);
    add("ld_mem_w1",   0, 0, 0, I_LD,  F_LD,  E_MEMR);
    add("ld_mem_rdy",  0, 0, 1, I_LD,  F_LD,  E_MEMR);
    add("ld_wb",       0, 0, 0, I_LD,  F_LD,  E_RET);
    add("beq_fetch_w", 0, 0, 0, I_BEQ, F_BRT, E_FQ);
    add("beq_fetch",   0, 1, 0, I_BEQ, F_BRT, E_FR);
    add("beq_decode",  0, 0, 0, I_BEQ, F_BRT, E_BUSY);
    add("beq_taken",   0, 0, 0, I_BEQ, F_BRT, E_BRT);
    add("bne_fetch",   0, 1, 0, I_BEQ, F_BRN, E_FR);
    add("bne_decode",  0, 0, 0, I_BEQ, F_BRN, E_BUSY);
    add("bne_exec",    0, 0, 0, I_BEQ, F_BRN, E_BRN);
    add("sd_fetch",    0, 1, 0, I_SD,  F_SD,  E_FR);
    add("sd_decode",   0, 0, 0, I_SD,  F_SD,  E_BUSY);
    add("sd_exec",     0, 0, 0, I_SD,  F_SD,  E_BUSY);
    add("sd_mem_rdy",  0, 0, 1, I_SD,  F_SD,  E_STR);
    add("sd2_fetch",   0, 1, 0, I_SD,  F_SD,  E_FR);
    add("sd2_decode",  0, 0, 0, I_SD,  F_SD,  E_BUSY);
    add("sd2_exec",    0, 0, 0, I_SD,  F_SD,  E_BUSY);
    add("sd2_mem_w0",  0, 0, 0, I_SD,  F_SD,  E_MEMW);
    add("sd2_mem_rdy", 0, 0, 1, I_SD,  F_SD,  E_STR);
    add("lim_fetch",   0, 1, 0, I_LD,  F_LD,  E_FR);
    add("lim_decode",  0, 0, 0, I_LD,  F_LD,  E_BUSY);
    add("lim_exec",    0, 0, 0, I_LD,  F_LD,  E_BUSY);
    add("lim_mem_w0",  0, 0, 0, I_LD,  F_LD,  E_MEMR);
    add("lim_mem_w1",  0, 0, 0, I_LD,  F_LD,  E_MEMR);
    add("lim_mem_w2",  0, 0, 0, I_LD,  F_LD,  E_MEMR);
    add("lim_mem_rdy", 0, 0, 1, I_LD,  F_LD,  E_MEMR);
    add("lim_wb",      0, 0, 0, I_LD,  F_LD,  E_RET);
    add("end_fetch",   0, 1, 0, I_END, F_0,   E_FR);
    add("end_decode",  0, 0, 0, I_END, F_0,   E_BUSY);
    add("end_halt",    0, 0, 0, I_END, F_0,   E_HALT);
    add("end_hold",    0, 0, 0, I_END, F_0,   E_HALT);
    add("end_restart", 1, 0, 0, I_END, F_0,   E_HALT);
    add("ill_fetch",   0, 1, 0, I_LUI, F_ALU, E_FR);
    add("ill_decode",  0, 0, 0, I_LUI, F_ALU, E_BUSY);
    add("ill_halt",    0, 0, 0, I_LUI, F_ALU, E_HILL);
    add("ill_restart", 1, 0, 0, I_LUI, F_ALU, E_HILL);
    add("add2_fetch",  0, 1, 0, I_ADD, F_ALU, E_FR);
    add("add2_decode", 0, 0, 0, I_ADD, F_ALU, E_BUSY);
    add("add2_exec",   0, 0, 0, I_ADD, F_ALU, E_RET);

    // Reset holds everything at zero even with activity on the inputs.
    drive(1, 1, 1, I_ADD, F_ALU);
    repeat (2) @(posedge clk);
    #2 check("rst_outs", {21'd0, outs()}, 32'd0);
    @(negedge clk);
    check("rst_outs_hold", {21'd0, outs()}, 32'd0);
    drive(0, 0, 0, I_END, F_0);
    rst_n = 1'b1;

    foreach (tv[i]) cyc(tv[i].name, tv[i].start, tv[i].ir, tv[i].dr, tv[i].instr, tv[i].fl, tv[i].exp);

    // Data-memory timeout: four stalled MEM cycles, then HALT with err_timeout.
    cyc("to_fetch",  0, 1, 0, I_LD, F_LD, E_FR);
    cyc("to_decode", 0, 0, 0, I_LD, F_LD, E_BUSY);
    cyc("to_exec",   0, 0, 0, I_LD, F_LD, E_BUSY);
    for (int k = 0; k < TO; k++) cyc($sformatf("to_mem_w%0d", k), 0, 0, 0, I_LD, F_LD, E_MEMR);
    cyc("to_halt",    0, 0, 0, I_LD, F_LD, E_HTO);
    cyc("to_restart", 1, 0, 0, I_LD, F_LD, E_HTO);

    // Instruction-fetch timeout, with errors already cleared by the restart.
    for (int k = 0; k < TO; k++) cyc($sformatf("ito_fetch_w%0d", k), 0, 0, 0, I_ADD, F_ALU, E_FQ);
    cyc("ito_halt",    0, 0, 0, I_ADD, F_ALU, E_HTO);
    cyc("ito_restart", 1, 0, 0, I_ADD, F_ALU, E_HTO);

    // Asynchronous reset in the middle of a data-memory wait.
    cyc("rm_fetch",  0, 1, 0, I_LD, F_LD, E_FR);
    cyc("rm_decode", 0, 0, 0, I_LD, F_LD, E_BUSY);
    cyc("rm_exec",   0, 0, 0, I_LD, F_LD, E_BUSY);
    cyc("rm_mem",    0, 0, 0, I_LD, F_LD, E_MEMR);
    #1 rst_n = 1'b0;
    #1 check("rst_mid_mem", {21'd0, outs()}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc("rm_idle", 0, 0, 0, I_END, F_0, E_IDLE);

`ifdef SEQ_PERF_CNT_EN
    cyc("pc_start", 1, 0, 0, I_END, F_0, E_IDLE);
    for (int k = 0; k < 3; k++) begin
      cyc($sformatf("pc_add%0d_f", k), 0, 1, 0, I_ADD, F_ALU, E_FR);
      cyc($sformatf("pc_add%0d_d", k), 0, 0, 0, I_ADD, F_ALU, E_BUSY);
      cyc($sformatf("pc_add%0d_e", k), 0, 0, 0, I_ADD, F_ALU, E_RET);
    end
    cyc("pc_end_f", 0, 1, 0, I_END, F_0, E_FR);
    cyc("pc_end_d", 0, 0, 0, I_END, F_0, E_BUSY);
    cyc("pc_halt",  0, 0, 0, I_END, F_0, E_HALT);
    check("retired_cnt", retired_cnt, 32'd3);
    check("cycle_cnt",   cycle_cnt,   32'd11);
    cyc("pc_hold",  0, 0, 0, I_END, F_0, E_HALT);
    check("cycle_cnt_hold", cycle_cnt, 32'd11);
    cyc("pc_restart", 1, 0, 0, I_END, F_0, E_HALT);
    cyc("pc_refetch", 0, 0, 0, I_END, F_0, E_FQ);
    check("retired_clr", retired_cnt, 32'd0);
    check("cycle_clr",   cycle_cnt,   32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
